// File: rtl/except_ctrl_if.sv
// MEM-stage / CP0 signal bundle for the exception controller.
// slave = except_ctrl side, master = pipeline/CP0 side driving the inputs.
interface except_ctrl_if;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    modport slave (
        input  excepttype_i, current_inst_addr_i, is_in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               flush_o, new_pc_o, busy_o
    );

    modport master (
        output excepttype_i, current_inst_addr_i, is_in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               flush_o, new_pc_o, busy_o
    );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks one exception, pulses its code to CP0,
// drives a multi-cycle flush and supplies the redirect PC (handler or EPC).
module except_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    except_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_INV  = 32'ha;
    localparam logic [31:0] EXC_TRAP = 32'hd;
    localparam logic [31:0] EXC_OVF  = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [3:0] LAST_CNT = 4'(FLUSH_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        int_pend_q, int_pend_d;

    logic        wb_status, wb_cause, wb_epc;
    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        int_req;
    logic [31:0] code;
    logic        is_eret;
    logic        is_idle;
    logic        accept;
    logic [31:0] accept_pc;
    logic        busy;

    assign wb_status = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == 5'd12);
    assign wb_cause  = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == 5'd13);
    assign wb_epc    = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == 5'd14);

    assign eff_status = wb_status ? bus.wb_cp0_data_i : bus.cp0_status_i;
    assign eff_epc    = wb_epc    ? bus.wb_cp0_data_i : bus.cp0_epc_i;

    // Only the software-writable Cause fields are forwarded from WB.
    always_comb begin
        eff_cause = bus.cp0_cause_i;
        if (wb_cause) begin
            eff_cause[9:8]   = bus.wb_cp0_data_i[9:8];
            eff_cause[23:22] = bus.wb_cp0_data_i[23:22];
        end
    end

    assign int_req = (|(eff_status[15:8] & eff_cause[15:8])) & eff_status[0] & ~eff_status[1];

    always_comb begin
        code    = EXC_NONE;
        is_eret = 1'b0;
        if (int_req || int_pend_q) begin
            code = EXC_INT;
        end else if (bus.excepttype_i[8]) begin
            code = EXC_SYS;
        end else if (bus.excepttype_i[9]) begin
            code = EXC_INV;
        end else if (bus.excepttype_i[10]) begin
            code = EXC_TRAP;
        end else if (bus.excepttype_i[11]) begin
            code = EXC_OVF;
        end else if (bus.excepttype_i[12]) begin
            code    = EXC_ERET;
            is_eret = 1'b1;
        end
    end

    assign is_idle   = (state_q == S_IDLE);
    assign accept    = !rst && is_idle && (bus.current_inst_addr_i != '0) && (code != EXC_NONE);
    assign accept_pc = is_eret ? eff_epc : HANDLER_ADDR;
    assign busy      = !rst && (state_q == S_FLUSH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        new_pc_d   = new_pc_q;
        int_pend_d = int_pend_q;
        if (is_idle) begin
            if (accept && (code == EXC_INT)) begin
                int_pend_d = 1'b0;
            end else if (!int_req) begin
                int_pend_d = 1'b0;
            end else if (bus.current_inst_addr_i == '0) begin
                int_pend_d = 1'b1;
            end
            if (accept && (FLUSH_CYCLES > 1)) begin
                state_d  = S_FLUSH;
                cnt_d    = 4'd1;
                new_pc_d = accept_pc;
            end
        end else begin
            if (cnt_q == LAST_CNT) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                new_pc_d = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            new_pc_q   <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            new_pc_q   <= new_pc_d;
            int_pend_q <= int_pend_d;
        end
    end

    assign bus.excepttype_o        = accept ? code : '0;
    assign bus.current_inst_addr_o = accept ? bus.current_inst_addr_i : '0;
    assign bus.is_in_delayslot_o   = accept & bus.is_in_delayslot_i;
    assign bus.flush_o             = accept | busy;
    assign bus.new_pc_o            = accept ? accept_pc : (busy ? new_pc_q : '0);
    assign bus.busy_o              = busy;

    logic unused_bits;
    assign unused_bits = ^{bus.excepttype_i[31:13], bus.excepttype_i[7:0],
                           eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0]};
endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed literal cases followed by randomized traffic,
// all cycles checked against a behavioural model of the exception rules.
module tb_except_ctrl;
    localparam logic [31:0] HANDLER = 32'h0000_0020;
    localparam int FC = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    except_ctrl_if bus ();

    except_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles of flush still owed after the accept cycle, held target, pending int.
    int          m_left;
    logic [31:0] m_pc;
    logic        m_pend;

    always @(negedge clk) begin
        logic [31:0] es, ec, ee, ecode, eaddr, enpc;
        logic        eds, eflush, ebusy, ireq;
        if (rst) begin
            m_left = 0;
            m_pc   = '0;
            m_pend = 1'b0;
        end else begin
            es = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) ? bus.wb_cp0_data_i : bus.cp0_status_i;
            ee = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ? bus.wb_cp0_data_i : bus.cp0_epc_i;
            ec = bus.cp0_cause_i;
            if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13)
                ec = (ec & ~32'h00C0_0300) | (bus.wb_cp0_data_i & 32'h00C0_0300);
            ireq = ((es[15:8] & ec[15:8]) != 8'h0) && es[0] && !es[1];

            ecode = 0; eaddr = 0; enpc = 0; eds = 0; eflush = 0; ebusy = 0;
            if (m_left > 0) begin
                eflush = 1; ebusy = 1; enpc = m_pc;
                m_left = m_left - 1;
            end else begin
                if (bus.current_inst_addr_i != 0) begin
                    if (ireq || m_pend)                ecode = 32'h1;
                    else if (bus.excepttype_i[8])      ecode = 32'h8;
                    else if (bus.excepttype_i[9])      ecode = 32'ha;
                    else if (bus.excepttype_i[10])     ecode = 32'hd;
                    else if (bus.excepttype_i[11])     ecode = 32'hc;
                    else if (bus.excepttype_i[12])     ecode = 32'he;
                end
                if (ecode != 0) begin
                    eaddr  = bus.current_inst_addr_i;
                    eds    = bus.is_in_delayslot_i;
                    eflush = 1;
                    enpc   = (ecode == 32'he) ? ee : HANDLER;
                    m_pc   = enpc;
                    m_left = FC - 1;
                    if (ecode == 32'h1 || !ireq) m_pend = 0;
                end else begin
                    if (!ireq) m_pend = 0;
                    else if (bus.current_inst_addr_i == 0) m_pend = 1;
                end
            end
            chk("excepttype", bus.excepttype_o, ecode);
            chk("inst_addr", bus.current_inst_addr_o, eaddr);
            chk("delayslot", 32'(bus.is_in_delayslot_o), 32'(eds));
            chk("flush", 32'(bus.flush_o), 32'(eflush));
            chk("new_pc", bus.new_pc_o, enpc);
            chk("busy", 32'(bus.busy_o), 32'(ebusy));
        end
    end

    task automatic idle_in();
        bus.excepttype_i        = '0;
        bus.current_inst_addr_i = '0;
        bus.is_in_delayslot_i   = 1'b0;
        bus.cp0_status_i        = '0;
        bus.cp0_cause_i         = '0;
        bus.cp0_epc_i           = '0;
        bus.wb_cp0_we_i         = 1'b0;
        bus.wb_cp0_waddr_i      = '0;
        bus.wb_cp0_data_i       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] f;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_new_pc", bus.new_pc_o, 32'h0);
        chk("rst_exc", bus.excepttype_o, 32'h0);

        // syscall
        tick(); bus.excepttype_i = 32'h100; bus.current_inst_addr_i = 32'h100;
        @(negedge clk);
        chk("sys_code", bus.excepttype_o, 32'h8);
        chk("sys_addr", bus.current_inst_addr_o, 32'h100);
        chk("sys_flush0", 32'(bus.flush_o), 32'h1);
        chk("sys_pc0", bus.new_pc_o, 32'h20);
        tick(); idle_in();
        @(negedge clk);
        chk("sys_code1", bus.excepttype_o, 32'h0);
        chk("sys_flush1", 32'(bus.flush_o), 32'h1);
        chk("sys_busy1", 32'(bus.busy_o), 32'h1);
        chk("sys_pc1", bus.new_pc_o, 32'h20);
        tick();
        @(negedge clk);
        chk("sys_flush2", 32'(bus.flush_o), 32'h0);
        chk("sys_pc2", bus.new_pc_o, 32'h0);

        // eret with EPC forwarded from WB
        tick(); bus.excepttype_i = 32'h1000; bus.current_inst_addr_i = 32'h104;
        bus.cp0_epc_i = 32'h123; bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd14;
        bus.wb_cp0_data_i = 32'h400;
        @(negedge clk);
        chk("eret_code", bus.excepttype_o, 32'he);
        chk("eret_pc", bus.new_pc_o, 32'h400);
        tick(); idle_in();
        @(negedge clk);
        chk("eret_pc_hold", bus.new_pc_o, 32'h400);

        // interrupt in delay slot, then masked by EXL
        tick(); bus.cp0_status_i = 32'h401; bus.cp0_cause_i = 32'h400;
        bus.current_inst_addr_i = 32'h200; bus.is_in_delayslot_i = 1'b1;
        @(negedge clk);
        chk("int_code", bus.excepttype_o, 32'h1);
        chk("int_ds", 32'(bus.is_in_delayslot_o), 32'h1);
        chk("int_addr", bus.current_inst_addr_o, 32'h200);
        tick(); idle_in();
        tick(); bus.cp0_status_i = 32'h403; bus.cp0_cause_i = 32'h400;
        bus.current_inst_addr_i = 32'h200; bus.is_in_delayslot_i = 1'b1;
        @(negedge clk);
        chk("exl_code", bus.excepttype_o, 32'h0);
        chk("exl_flush", 32'(bus.flush_o), 32'h0);

        // interrupt during bubble, taken on next real instruction
        tick(); bus.cp0_status_i = 32'h401; bus.is_in_delayslot_i = 1'b0;
        bus.current_inst_addr_i = 32'h0;
        @(negedge clk);
        chk("bub_flush", 32'(bus.flush_o), 32'h0);
        tick(); bus.current_inst_addr_i = 32'h300;
        @(negedge clk);
        chk("pend_code", bus.excepttype_o, 32'h1);
        chk("pend_addr", bus.current_inst_addr_o, 32'h300);
        tick(); idle_in();

        // overflow+trap -> trap; trap during flush dropped
        tick(); bus.excepttype_i = 32'hC00; bus.current_inst_addr_i = 32'h500;
        @(negedge clk);
        chk("prio_code", bus.excepttype_o, 32'hd);
        tick(); bus.excepttype_i = 32'h400; bus.current_inst_addr_i = 32'h504;
        @(negedge clk);
        chk("drop_code", bus.excepttype_o, 32'h0);
        chk("drop_flush", 32'(bus.flush_o), 32'h1);
        tick(); idle_in();
        @(negedge clk);
        chk("drop_end", 32'(bus.flush_o), 32'h0);

        // reset during first flush cycle
        tick(); bus.excepttype_i = 32'h100; bus.current_inst_addr_i = 32'h600;
        @(negedge clk);
        chk("rf_code", bus.excepttype_o, 32'h8);
        tick(); idle_in(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rf_flush", 32'(bus.flush_o), 32'h0);
        chk("rf_busy", 32'(bus.busy_o), 32'h0);
        chk("rf_pc", bus.new_pc_o, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            f = $urandom;
            f[12:8] = '0;
            for (int b = 8; b <= 12; b++)
                if ($urandom_range(0, 4) == 0) f[b] = 1'b1;
            bus.excepttype_i        = f;
            bus.current_inst_addr_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            bus.is_in_delayslot_i   = 1'($urandom_range(0, 1));
            bus.cp0_status_i        = $urandom;
            bus.cp0_cause_i         = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            bus.cp0_epc_i           = $urandom;
            bus.wb_cp0_we_i         = 1'($urandom_range(0, 1));
            bus.wb_cp0_waddr_i      = 5'($urandom_range(11, 15));
            bus.wb_cp0_data_i       = $urandom;
            rst                     = ($urandom_range(0, 99) == 0);
        end
        tick(); idle_in(); rst = 1'b0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
